// File: rtl/mem_stage_pkg.sv
// Shared widths, opcode encodings and FSM state type for the memory-access stage.
// Load/store opcode values match the execute stage's encodings.
package mem_stage_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_W      = 32;
  localparam int ALUOP_W    = 8;

  localparam logic [ALUOP_W-1:0] ME_NOP_OP  = 8'h00;
  localparam logic [ALUOP_W-1:0] EX_ADD_OP  = 8'h20;
  localparam logic [ALUOP_W-1:0] EX_LB_OP   = 8'hE0;
  localparam logic [ALUOP_W-1:0] EX_LH_OP   = 8'hE1;
  localparam logic [ALUOP_W-1:0] EX_LW_OP   = 8'hE3;
  localparam logic [ALUOP_W-1:0] EX_LBU_OP  = 8'hE4;
  localparam logic [ALUOP_W-1:0] EX_LHU_OP  = 8'hE5;
  localparam logic [ALUOP_W-1:0] EX_SB_OP   = 8'hE8;
  localparam logic [ALUOP_W-1:0] EX_SH_OP   = 8'hE9;
  localparam logic [ALUOP_W-1:0] EX_SW_OP   = 8'hEB;

  typedef enum logic [1:0] {
    ME_IDLE,
    ME_WAIT_GNT,
    ME_XFER,
    ME_DONE
  } me_state_t;

  // Byte count of a memory op; 0 marks a non-memory op.
  function automatic logic [2:0] op_bytes(input logic [ALUOP_W-1:0] op);
    case (op)
      EX_LB_OP, EX_LBU_OP, EX_SB_OP: op_bytes = 3'd1;
      EX_LH_OP, EX_LHU_OP, EX_SH_OP: op_bytes = 3'd2;
      EX_LW_OP, EX_SW_OP:            op_bytes = 3'd4;
      default:                       op_bytes = 3'd0;
    endcase
  endfunction

  function automatic logic is_store(input logic [ALUOP_W-1:0] op);
    is_store = (op == EX_SB_OP) || (op == EX_SH_OP) || (op == EX_SW_OP);
  endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Sign/zero extension of the little-endian assembled load value.
module mem_load_ext
  import mem_stage_pkg::*;
(
  input  logic [REG_W-1:0]   raw,
  input  logic [ALUOP_W-1:0] aluop,
  output logic [REG_W-1:0]   ext
);

  always_comb begin
    case (aluop)
      EX_LB_OP:  ext = {{24{raw[7]}}, raw[7:0]};
      EX_LBU_OP: ext = {24'd0, raw[7:0]};
      EX_LH_OP:  ext = {{16{raw[15]}}, raw[15:0]};
      EX_LHU_OP: ext = {16'd0, raw[15:0]};
      default:   ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: byte-serial loads/stores over an arbitrated 8-bit port,
// stalling the pipeline until the access completes; other ops pass through.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int MEM_ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [REG_W-1:0]      wdata_i,
  input  logic [ALUOP_W-1:0]    aluop_i,
  input  logic [REG_W-1:0]      mem_addr_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [REG_W-1:0]      wdata_o,
  output logic                  stall_req_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [MEM_ADDR_W-1:0] mem_a_o,
  output logic                  mem_wr_o,
  output logic [7:0]            mem_dout_o,
  input  logic [7:0]            mem_din_i
);

  me_state_t        state_reg, state_next;
  logic [2:0]       cnt_reg, cnt_next;
  logic [REG_W-1:0] asm_reg, asm_next;

  logic [2:0]       n_bytes;
  logic [2:0]       last_cnt;
  logic             is_mem;
  logic             st;
  logic [1:0]       cap_idx;
  logic [REG_W-1:0] byte_addr;
  logic [REG_W-1:0] ext_data;

  assign n_bytes   = op_bytes(aluop_i);
  assign is_mem    = (n_bytes != 3'd0);
  assign st        = is_store(aluop_i);
  // Loads need one extra cycle to capture the byte returned for the last address.
  assign last_cnt  = st ? (n_bytes - 3'd1) : n_bytes;
  assign cap_idx   = cnt_reg[1:0] - 2'd1;
  assign byte_addr = mem_addr_i + {29'd0, cnt_reg};

  mem_load_ext u_load_ext (
    .raw   (asm_reg),
    .aluop (aluop_i),
    .ext   (ext_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ME_IDLE;
      cnt_reg   <= 3'd0;
      asm_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      asm_reg   <= asm_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    asm_next    = asm_reg;
    wd_o        = '0;
    wreg_o      = 1'b0;
    wdata_o     = '0;
    stall_req_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_a_o     = '0;
    mem_wr_o    = 1'b0;
    mem_dout_o  = 8'd0;

    case (state_reg)
      ME_IDLE: begin
        cnt_next = 3'd0;
        if (is_mem) begin
          mem_req_o   = 1'b1;
          stall_req_o = 1'b1;
          asm_next    = '0;
          state_next  = mem_gnt_i ? ME_XFER : ME_WAIT_GNT;
        end else begin
          wd_o    = wd_i;
          wreg_o  = wreg_i;
          wdata_o = wdata_i;
        end
      end

      ME_WAIT_GNT: begin
        mem_req_o   = 1'b1;
        stall_req_o = 1'b1;
        if (mem_gnt_i) state_next = ME_XFER;
      end

      ME_XFER: begin
        mem_req_o   = 1'b1;
        stall_req_o = 1'b1;
        cnt_next    = cnt_reg + 3'd1;
        if (cnt_reg < n_bytes) begin
          mem_a_o  = byte_addr[MEM_ADDR_W-1:0];
          mem_wr_o = st;
          if (st) mem_dout_o = wdata_i[{cnt_reg[1:0], 3'b000} +: 8];
        end
        // Read data lags its address by one cycle, so byte k-1 lands now.
        if (!st && cnt_reg != 3'd0) asm_next[{cap_idx, 3'b000} +: 8] = mem_din_i;
        if (cnt_reg >= last_cnt) state_next = ME_DONE;
      end

      ME_DONE: begin
        cnt_next   = 3'd0;
        state_next = ME_IDLE;
        wd_o       = wd_i;
        wreg_o     = st ? 1'b0 : wreg_i;
        wdata_o    = st ? '0 : ext_data;
      end

      default: state_next = ME_IDLE;
    endcase

    if (rst) begin
      wd_o        = '0;
      wreg_o      = 1'b0;
      wdata_o     = '0;
      stall_req_o = 1'b0;
      mem_req_o   = 1'b0;
      mem_a_o     = '0;
      mem_wr_o    = 1'b0;
      mem_dout_o  = 8'd0;
    end
  end

endmodule
